// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one fixed-latency memory port between
// instruction fetch and data memory, with per-requester stalls.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_abort_i,
    output logic              if_done_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_done_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_stall_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
        $error("mem_port_arbiter: MEM_LAT must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

    state_t state, state_n;
    logic [3:0] cnt;
    logic last_dm, abort_seen, lat_we;
    logic last, aborted, arb, if_elig, dm_elig, grant_dm, grant_if, grant;

    assign last     = cnt == 4'(MEM_LAT);
    assign aborted  = abort_seen | if_abort_i;
    // An aborted fetch produces no done cycle, so the port is offered again at its final edge.
    assign arb      = state == IDLE || (state == BUSY_IF && last && aborted);
    assign if_elig  = if_req_i & ~if_done_o;
    assign dm_elig  = dm_req_i & ~dm_done_o;
    assign grant_dm = arb & dm_elig & (~if_elig | ~last_dm);
    assign grant_if = arb & if_elig & ~grant_dm;
    assign grant    = grant_dm | grant_if;

    always_comb begin
        state_n = (state != IDLE && last) ? IDLE : state;
        state_n = grant_dm ? BUSY_DM : grant_if ? BUSY_IF : state_n;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            last_dm     <= 1'b0;
            abort_seen  <= 1'b0;
            lat_we      <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
            if_done_o   <= 1'b0;
            dm_done_o   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= grant ? 4'd1 : (state != IDLE && !last) ? cnt + 4'd1 : 4'd0;
            abort_seen <= state == BUSY_IF && !last && aborted;
            if_done_o  <= state == BUSY_IF && last && !aborted;
            dm_done_o  <= state == BUSY_DM && last;
            if (state == BUSY_IF && last && !aborted)
                if_rdata_o <= mem_rdata_i;
            if (state == BUSY_DM && last && !lat_we)
                dm_rdata_o <= mem_rdata_i;
            if (grant) begin
                last_dm     <= grant_dm;
                lat_we      <= grant_dm & dm_we_i;
                mem_addr_o  <= grant_dm ? dm_addr_i : if_addr_i;
                mem_wdata_o <= grant_dm ? dm_wdata_i : '0;
            end
        end
    end

    assign mem_en_o   = state != IDLE && cnt == 4'd1;
    assign mem_we_o   = mem_en_o & lat_we;
    assign if_stall_o = if_req_i & ~if_done_o;
    assign dm_stall_o = dm_req_i & ~dm_done_o;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, hand sequences and a randomized run
// checked against a cycle-number based transaction model.
module tb_mem_port_arbiter;
    localparam int LAT = 2;
    localparam logic T = 1'b1, F = 1'b0;

    logic clk = 1'b0, rst = 1'b1;
    logic if_req_i = 0, if_abort_i = 0, dm_req_i = 0, dm_we_i = 0;
    logic [31:0] if_addr_i = 0, dm_addr_i = 0, dm_wdata_i = 0, mem_rdata_i;
    logic if_done_o, if_stall_o, dm_done_o, dm_stall_o, mem_en_o, mem_we_o;
    logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
    logic use_hash = 1'b0;
    logic [31:0] mem_data = 0;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] hash(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h1234_5678;
    endfunction

    assign mem_rdata_i = use_hash ? hash(mem_addr_o) : mem_data;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk_i(clk), .rst_i(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_abort_i(if_abort_i),
        .if_done_o(if_done_o), .if_rdata_o(if_rdata_o), .if_stall_o(if_stall_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_done_o(dm_done_o), .dm_rdata_o(dm_rdata_o), .dm_stall_o(dm_stall_o),
        .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h @%0t", n, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        ifr;
        logic [31:0] ifa;
        logic        dmr;
        logic [31:0] dma, mrd;
        logic        en;
        logic [31:0] addr;
        logic        ifd, dmd, ifs, dms;
        logic [31:0] ifrd, dmrd;
    } vec_t;

    vec_t tbl[13];

    // model state: everything expressed as absolute cycle numbers
    int gnt_c, busy_end, if_done_c, dm_done_c, owner;
    logic aborted, m_last_dm, g_we, ie, de, gd;
    logic [31:0] g_addr, g_wdata, m_ifrd, m_dmrd;

    initial begin
        tbl[0]  = '{T, 'h10, F, 0, 0,            F, 0,     F, F, T, F, 0, 0};
        tbl[1]  = '{T, 'h10, F, 0, 0,            T, 'h10,  F, F, T, F, 0, 0};
        tbl[2]  = '{T, 'h10, F, 0, 'hDEADBEEF,   F, 'h10,  F, F, T, F, 0, 0};
        tbl[3]  = '{T, 'h10, F, 0, 0,            F, 'h10,  T, F, F, F, 'hDEADBEEF, 0};
        tbl[4]  = '{F, 0,    F, 0, 0,            F, 'h10,  F, F, F, F, 'hDEADBEEF, 0};
        tbl[5]  = '{T, 'h4,  T, 'h100, 'hCAFE0001, F, 'h10,  F, F, T, T, 'hDEADBEEF, 0};
        tbl[6]  = '{T, 'h4,  T, 'h100, 'hCAFE0001, T, 'h100, F, F, T, T, 'hDEADBEEF, 0};
        tbl[7]  = '{T, 'h4,  T, 'h100, 'hCAFE0001, F, 'h100, F, F, T, T, 'hDEADBEEF, 0};
        tbl[8]  = '{T, 'h4,  T, 'h100, 'h13,     F, 'h100, F, T, T, F, 'hDEADBEEF, 'hCAFE0001};
        tbl[9]  = '{T, 'h4,  F, 0, 'h13,         T, 'h4,   F, F, T, F, 'hDEADBEEF, 'hCAFE0001};
        tbl[10] = '{T, 'h4,  F, 0, 'h13,         F, 'h4,   F, F, T, F, 'hDEADBEEF, 'hCAFE0001};
        tbl[11] = '{T, 'h4,  F, 0, 0,            F, 'h4,   T, F, F, F, 'h13, 'hCAFE0001};
        tbl[12] = '{F, 0,    F, 0, 0,            F, 'h4,   F, F, F, F, 'h13, 'hCAFE0001};

        repeat (3) @(posedge clk);
        @(negedge clk); rst = 0; #1;
        chk("rst_en", mem_en_o, 0);      chk("rst_we", mem_we_o, 0);
        chk("rst_addr", mem_addr_o, 0);  chk("rst_wdata", mem_wdata_o, 0);
        chk("rst_ifd", if_done_o, 0);    chk("rst_dmd", dm_done_o, 0);
        chk("rst_ifrd", if_rdata_o, 0);  chk("rst_dmrd", dm_rdata_o, 0);
        chk("rst_ifs", if_stall_o, 0);   chk("rst_dms", dm_stall_o, 0);

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if_req_i = tbl[i].ifr; if_addr_i = tbl[i].ifa;
            dm_req_i = tbl[i].dmr; dm_addr_i = tbl[i].dma; mem_data = tbl[i].mrd;
            #1;
            chk($sformatf("v%0d_en", i), mem_en_o, tbl[i].en);
            chk($sformatf("v%0d_we", i), mem_we_o, 0);
            chk($sformatf("v%0d_addr", i), mem_addr_o, tbl[i].addr);
            chk($sformatf("v%0d_ifd", i), if_done_o, tbl[i].ifd);
            chk($sformatf("v%0d_dmd", i), dm_done_o, tbl[i].dmd);
            chk($sformatf("v%0d_ifs", i), if_stall_o, tbl[i].ifs);
            chk($sformatf("v%0d_dms", i), dm_stall_o, tbl[i].dms);
            chk($sformatf("v%0d_ifrd", i), if_rdata_o, tbl[i].ifrd);
            chk($sformatf("v%0d_dmrd", i), dm_rdata_o, tbl[i].dmrd);
        end

        // store leaves load data untouched
        @(negedge clk); dm_req_i = 1; dm_we_i = 1; dm_addr_i = 'h20; dm_wdata_i = 'h55AA; #1;
        chk("st_dms", dm_stall_o, 1);
        @(negedge clk); #1;
        chk("st_en", mem_en_o, 1); chk("st_we", mem_we_o, 1);
        chk("st_addr", mem_addr_o, 'h20); chk("st_wdata", mem_wdata_o, 'h55AA);
        @(negedge clk); #1; chk("st_en2", mem_en_o, 0);
        @(negedge clk); #1; chk("st_dmd", dm_done_o, 1); chk("st_dmrd", dm_rdata_o, 'hCAFE0001);

        // fetch aborted mid-flight; DM granted on the fetch's final edge
        @(negedge clk); dm_req_i = 0; dm_we_i = 0; if_req_i = 1; if_addr_i = 'h40; #1;
        @(negedge clk); if_abort_i = 1; dm_req_i = 1; dm_addr_i = 'h50; #1;
        chk("ab_en", mem_en_o, 1); chk("ab_addr", mem_addr_o, 'h40); chk("ab_we", mem_we_o, 0);
        @(negedge clk); if_abort_i = 0; if_req_i = 0; mem_data = 'h77; #1;
        chk("ab_ifd1", if_done_o, 0);
        @(negedge clk); #1;
        chk("ab_ifd2", if_done_o, 0); chk("ab_dm_en", mem_en_o, 1); chk("ab_dm_addr", mem_addr_o, 'h50);
        @(negedge clk); #1; chk("ab_en3", mem_en_o, 0);
        @(negedge clk); #1;
        chk("ab_dmd", dm_done_o, 1); chk("ab_dmrd", dm_rdata_o, 'h77);
        chk("ab_ifd3", if_done_o, 0); chk("ab_ifrd", if_rdata_o, 'h13);

        // reset while DM access is in its enable cycle
        @(negedge clk); dm_addr_i = 'h60; #1;
        @(negedge clk); rst = 1; #1; chk("rs_en", mem_en_o, 1); chk("rs_addr", mem_addr_o, 'h60);
        @(negedge clk); rst = 0; if_req_i = 1; if_addr_i = 'h8; #1;
        chk("rs_en0", mem_en_o, 0); chk("rs_addr0", mem_addr_o, 0); chk("rs_wd0", mem_wdata_o, 0);
        chk("rs_dmd0", dm_done_o, 0); chk("rs_ifd0", if_done_o, 0);
        chk("rs_dmrd0", dm_rdata_o, 0); chk("rs_ifrd0", if_rdata_o, 0);
        @(negedge clk); #1; chk("rs_dmfirst_en", mem_en_o, 1); chk("rs_dmfirst_addr", mem_addr_o, 'h60);
        @(negedge clk); #1;
        @(negedge clk); #1; chk("rs_dmd", dm_done_o, 1); chk("rs_ifd", if_done_o, 0);

        // randomized run against the transaction model
        @(negedge clk); rst = 1; use_hash = 1; if_req_i = 0; dm_req_i = 0; dm_we_i = 0;
        gnt_c = -100; busy_end = -1; if_done_c = -100; dm_done_c = -100; owner = 0;
        aborted = 0; m_last_dm = 0; g_we = 0; g_addr = 0; g_wdata = 0; m_ifrd = 0; m_dmrd = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); rst = 0;
            if (!if_req_i || c == if_done_c) begin
                if_req_i = $urandom_range(0, 2) != 0; if_addr_i = $urandom;
            end
            if (!dm_req_i || c == dm_done_c) begin
                dm_req_i = $urandom_range(0, 2) != 0; dm_we_i = $urandom_range(0, 1) == 1;
                dm_addr_i = $urandom; dm_wdata_i = $urandom;
            end
            if_abort_i = $urandom_range(0, 9) == 0;
            #1;
            chk("r_en", mem_en_o, c == gnt_c + 1);
            chk("r_we", mem_we_o, c == gnt_c + 1 && g_we);
            chk("r_addr", mem_addr_o, g_addr);
            chk("r_wdata", mem_wdata_o, g_wdata);
            chk("r_ifd", if_done_o, c == if_done_c);
            chk("r_dmd", dm_done_o, c == dm_done_c);
            chk("r_ifrd", if_rdata_o, m_ifrd);
            chk("r_dmrd", dm_rdata_o, m_dmrd);
            chk("r_ifs", if_stall_o, if_req_i && c != if_done_c);
            chk("r_dms", dm_stall_o, dm_req_i && c != dm_done_c);
            if (owner == 1 && c > gnt_c && c <= busy_end && if_abort_i) aborted = 1;
            if (c == busy_end && owner == 1 && !aborted) begin
                m_ifrd = hash(g_addr); if_done_c = c + 1;
            end
            if (c == busy_end && owner == 2) begin
                if (!g_we) m_dmrd = hash(g_addr);
                dm_done_c = c + 1;
            end
            if (c > busy_end || (c == busy_end && owner == 1 && aborted)) begin
                ie = if_req_i && c != if_done_c;
                de = dm_req_i && c != dm_done_c;
                if (ie || de) begin
                    gd = de && (!ie || !m_last_dm);
                    owner = gd ? 2 : 1; m_last_dm = gd; aborted = 0;
                    gnt_c = c; busy_end = c + LAT;
                    g_addr = gd ? dm_addr_i : if_addr_i;
                    g_wdata = gd ? dm_wdata_i : 0;
                    g_we = gd && dm_we_i;
                end
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
